// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback stage: write kinds,
// buffered entry payload, flag register layout and the byte-merge helper.
package alu_wb_pkg;

  localparam int unsigned WB_DATA_W = 16;
  localparam int unsigned WB_ADDR_W = 3;
  localparam int unsigned WB_DEPTH  = 2;
  localparam int unsigned WB_CNT_W  = 2;

  localparam logic [1:0] WB_FULL       = 2'b00;
  localparam logic [1:0] WB_HIGH       = 2'b01;
  localparam logic [1:0] WB_LOW        = 2'b10;
  localparam logic [1:0] WB_FLAGS_ONLY = 2'b11;

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic                 carry;
    logic                 overflow;
    logic                 equal;
    logic [WB_ADDR_W-1:0] dest;
    logic [1:0]           kind;
    logic                 flag_en;
  } wb_entry_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic eq;
  } wb_flags_t;

  // Combine the new byte with the destination's current contents.
  function automatic logic [WB_DATA_W-1:0] wb_merge(
    input logic [1:0]           kind,
    input logic [WB_DATA_W-1:0] result,
    input logic [WB_DATA_W-1:0] old
  );
    logic [WB_DATA_W-1:0] data;
    data = result;
    case (kind)
      WB_HIGH: data = {result[7:0], old[7:0]};
      WB_LOW:  data = {old[15:8], result[7:0]};
      default: data = result;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO of writeback entries; head is read straight
// from storage so consumers see it with no extra latency.
module wb_fifo2
  import alu_wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  wb_entry_t           push_data,
  input  logic                pop,
  output wb_entry_t           head,
  output logic [WB_CNT_W-1:0] count
);

  wb_entry_t mem [WB_DEPTH];
  logic      rd_ptr;
  logic      wr_ptr;
  logic      push_ok;
  logic      pop_ok;

  assign push_ok = push && (count != WB_CNT_W'(WB_DEPTH));
  assign pop_ok  = pop && (count != '0);

  // Storage resets to zero so the head reads as an all-zero entry after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + WB_CNT_W'(1);
        2'b01:   count <= count - WB_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers results, commits them to the register file
// with byte merge, and keeps the flag register in commit order.
// Optional flag register enabled by defining ALU_WB_FLAGS_EN.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_carry,
  input  logic                  in_overflow,
  input  logic                  in_equal,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [1:0]            in_kind,
  input  logic                  in_flag_en,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]     rf_rd_data,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  flag_eq
);

  wb_entry_t           push_entry;
  wb_entry_t           head;
  logic [WB_CNT_W-1:0] count;
  logic                head_valid;
  logic                head_writes;
  logic                push;
  logic                pop;

  assign in_ready    = (count != WB_CNT_W'(WB_DEPTH));
  assign head_valid  = (count != '0);
  assign head_writes = (head.kind != WB_FLAGS_ONLY);
  assign push        = in_valid && in_ready;
  // FLAGS_ONLY entries never touch the write port, so they retire unconditionally.
  assign pop         = head_valid && (!head_writes || wr_ready);

  always_comb begin
    push_entry          = '0;
    push_entry.result   = in_result;
    push_entry.carry    = in_carry;
    push_entry.overflow = in_overflow;
    push_entry.equal    = in_equal;
    push_entry.dest     = in_dest;
    push_entry.kind     = in_kind;
    push_entry.flag_en  = in_flag_en;
  end

  wb_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Merge read happens at commit: earlier writes to the same register are done.
  assign rf_rd_addr = head.dest;
  assign wr_en      = head_valid && head_writes;
  assign wr_addr    = head.dest;
  assign wr_data    = wb_merge(head.kind, head.result, rf_rd_data);

`ifdef ALU_WB_FLAGS_EN
  wb_flags_t flags_q;

  // Z and N come from the raw ALU result, not the merged write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (pop && head.flag_en) begin
      flags_q.z  <= (head.result == '0);
      flags_q.n  <= head.result[WB_DATA_W-1];
      flags_q.c  <= head.carry;
      flags_q.v  <= head.overflow;
      flags_q.eq <= head.equal;
    end
  end

  assign flag_z  = flags_q.z;
  assign flag_n  = flags_q.n;
  assign flag_c  = flags_q.c;
  assign flag_v  = flags_q.v;
  assign flag_eq = flags_q.eq;
`else
  logic unused_flag_fields;
  assign unused_flag_fields = ^{head.carry, head.overflow, head.equal, head.flag_en};

  assign flag_z  = 1'b0;
  assign flag_n  = 1'b0;
  assign flag_c  = 1'b0;
  assign flag_v  = 1'b0;
  assign flag_eq = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios then random
// traffic, compared each cycle against a queue-based reference model.
module tb_alu_writeback;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int K_FULL  = 0;
  localparam int K_HIGH  = 1;
  localparam int K_LOW   = 2;
  localparam int K_FLAGS = 3;
`ifdef ALU_WB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_result = '0;
  logic          in_carry = 1'b0;
  logic          in_overflow = 1'b0;
  logic          in_equal = 1'b0;
  logic [AW-1:0] in_dest = '0;
  logic [1:0]    in_kind = '0;
  logic          in_flag_en = 1'b0;
  logic [AW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          wr_en;
  logic          wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          flag_z, flag_n, flag_c, flag_v, flag_eq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] rf [8];
  assign rf_rd_data = rf[rf_rd_addr];

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_result   (in_result),
    .in_carry    (in_carry),
    .in_overflow (in_overflow),
    .in_equal    (in_equal),
    .in_dest     (in_dest),
    .in_kind     (in_kind),
    .in_flag_en  (in_flag_en),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .wr_en       (wr_en),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .flag_eq     (flag_eq)
  );

  typedef struct {
    int unsigned result;
    bit          c;
    bit          v;
    bit          e;
    int          dest;
    int          kind;
    bit          fen;
  } m_ent_t;

  m_ent_t m_q[$];
  bit mz, mn, mc, mv, meq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected register-file write for an entry, from the current model RF.
  function automatic logic [15:0] exp_wdata(input m_ent_t e);
    int unsigned old;
    old = 32'(rf[e.dest]);
    if (e.kind == K_HIGH) return 16'(((e.result % 256) * 256) + (old % 256));
    if (e.kind == K_LOW)  return 16'(((old / 256) * 256) + (e.result % 256));
    return 16'(e.result);
  endfunction

  task automatic check_flags(input string t);
    check_eq({t, "_z"},  32'(flag_z),  32'(FLAGS_ON & mz));
    check_eq({t, "_n"},  32'(flag_n),  32'(FLAGS_ON & mn));
    check_eq({t, "_c"},  32'(flag_c),  32'(FLAGS_ON & mc));
    check_eq({t, "_v"},  32'(flag_v),  32'(FLAGS_ON & mv));
    check_eq({t, "_eq"}, 32'(flag_eq), 32'(FLAGS_ON & meq));
  endtask

  task automatic set_in(input bit v, input int kind, input int unsigned res, input int dest,
                        input bit fen, input bit c, input bit ov, input bit eq);
    in_valid    = v;
    in_kind     = 2'(kind);
    in_result   = 16'(res);
    in_dest     = 3'(dest);
    in_flag_en  = fen;
    in_carry    = c;
    in_overflow = ov;
    in_equal    = eq;
  endtask

  // One clock: check outputs against the model, then advance model and DUT together.
  task automatic step();
    m_ent_t e, h;
    bit do_push, do_pop, do_wr;
    logic [15:0] wd;
    @(negedge clk);
    check_eq("in_ready", 32'(in_ready), 32'(m_q.size() != 2));
    check_eq("wr_en", 32'(wr_en), 32'(m_q.size() > 0 && m_q[0].kind != K_FLAGS));
    do_wr = 1'b0;
    wd = '0;
    if (m_q.size() > 0) begin
      h = m_q[0];
      if (h.kind != K_FLAGS) begin
        wd = exp_wdata(h);
        check_eq("wr_addr", 32'(wr_addr), 32'(h.dest));
        check_eq("wr_data", 32'(wr_data), 32'(wd));
      end
    end
    check_flags("flag");
    do_push = in_valid && (m_q.size() != 2);
    do_pop  = (m_q.size() > 0) && (m_q[0].kind == K_FLAGS || wr_ready);
    e.result = 32'(in_result);
    e.c = in_carry; e.v = in_overflow; e.e = in_equal;
    e.dest = int'(in_dest); e.kind = int'(in_kind); e.fen = in_flag_en;
    @(posedge clk);
    if (do_pop) begin
      h = m_q.pop_front();
      if (h.kind != K_FLAGS) rf[h.dest] = wd;
      if (h.fen) begin
        mz = (h.result == 0);
        mn = (h.result >= 32768);
        mc = h.c; mv = h.v; meq = h.e;
      end
    end
    if (do_push) m_q.push_back(e);
    #1;
  endtask

  initial begin
    int first_dest;
    for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
    mz = 0; mn = 0; mc = 0; mv = 0; meq = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    check_flags("rst_flag");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FULL write on an idle port
    wr_ready = 1'b1;
    set_in(1, K_FULL, 16'h1234, 3, 1, 0, 0, 0);
    step();
    set_in(0, K_FULL, 0, 0, 0, 0, 0, 0);
    check_eq("full_wr_en", 32'(wr_en), 32'd1);
    check_eq("full_wr_addr", 32'(wr_addr), 32'd3);
    check_eq("full_wr_data", 32'(wr_data), 32'h1234);
    step();
    check_eq("full_flag_z", 32'(flag_z), 32'd0);
    check_eq("full_flag_n", 32'(flag_n), 32'd0);

    // HIGH and LOW merges against R5 = 0x00AB
    rf[5] = 16'h00AB;
    set_in(1, K_HIGH, 16'hFFCD, 5, 0, 0, 0, 0);
    step();
    set_in(0, K_FULL, 0, 0, 0, 0, 0, 0);
    check_eq("high_wr_data", 32'(wr_data), 32'hCDAB);
    step();
    check_eq("high_rf5", 32'(rf[5]), 32'hCDAB);
    rf[5] = 16'h00AB;
    set_in(1, K_LOW, 16'hFFCD, 5, 0, 0, 0, 0);
    step();
    set_in(0, K_FULL, 0, 0, 0, 0, 0, 0);
    check_eq("low_wr_data", 32'(wr_data), 32'h00CD);
    step();

    // Backpressure: third entry is held until the port drains
    wr_ready = 1'b0;
    set_in(1, K_FULL, 16'h1111, 1, 1, 1, 0, 1);
    step();
    set_in(1, K_FULL, 16'h8222, 2, 1, 0, 1, 0);
    step();
    check_eq("bp_in_ready_full", 32'(in_ready), 32'd0);
    set_in(1, K_FULL, 16'h0333, 4, 1, 1, 1, 1);
    step();
    step();
    check_eq("bp_in_ready_held", 32'(in_ready), 32'd0);
    check_eq("bp_wr_addr_hold", 32'(wr_addr), 32'd1);
    check_eq("bp_wr_data_hold", 32'(wr_data), 32'h1111);
    wr_ready = 1'b1;
    step();
    check_eq("bp_second_addr", 32'(wr_addr), 32'd2);
    step();
    set_in(0, K_FULL, 0, 0, 0, 0, 0, 0);
    check_eq("bp_third_addr", 32'(wr_addr), 32'd4);
    step();
    step();

    // FLAGS_ONLY retires without writing, even with the port stalled
    wr_ready = 1'b0;
    set_in(1, K_FLAGS, 16'h0000, 6, 1, 1, 0, 0);
    step();
    set_in(0, K_FULL, 0, 0, 0, 0, 0, 0);
    check_eq("fo_wr_en", 32'(wr_en), 32'd0);
    step();
    check_eq("fo_in_ready", 32'(in_ready), 32'd1);
    check_eq("fo_flag_z", 32'(flag_z), 32'(FLAGS_ON));
    check_eq("fo_flag_c", 32'(flag_c), 32'(FLAGS_ON));
    check_eq("fo_flag_n", 32'(flag_n), 32'd0);
    set_in(1, K_FLAGS, 16'h8001, 6, 0, 0, 1, 0);
    step();
    set_in(0, K_FULL, 0, 0, 0, 0, 0, 0);
    step();
    check_eq("fo_noen_z", 32'(flag_z), 32'(FLAGS_ON));
    check_eq("fo_noen_n", 32'(flag_n), 32'd0);

    // Reset with two entries pending
    set_in(1, K_FULL, 16'hBEEF, 7, 1, 1, 1, 1);
    step();
    set_in(1, K_HIGH, 16'h5A5A, 0, 1, 0, 0, 0);
    step();
    set_in(0, K_FULL, 0, 0, 0, 0, 0, 0);
    check_eq("mid_pre_wr_en", 32'(wr_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    m_q.delete();
    mz = 0; mn = 0; mc = 0; mv = 0; meq = 0;
    check_flags("mid_rst_flag");
    wr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      int unsigned res;
      case ($urandom_range(0, 5))
        0:       res = 0;
        1:       res = 32'h8000 | $urandom_range(0, 255);
        default: res = $urandom_range(0, 65535);
      endcase
      set_in(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)), res,
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wr_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    set_in(0, K_FULL, 0, 0, 0, 0, 0, 0);
    wr_ready = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
